// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ADD/SUB/AND/XOR/NOP, shift-add MUL and restoring DIV over W cycles.
// Optional divider enabled by defining ALU_SEQ_DIV_EN; without it DIV behaves as NOP.
module alu_seq #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       sel,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic [2*W-1:0]   result,
  output logic             valid,
  output logic             busy,
  output logic             dz
);

  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_SHORT, S_ITER, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [2*W-1:0]   r_result, r_work, w_work_step, w_short_res;
  logic [W-1:0]     r_opnd;
  logic [CW-1:0]    r_cnt;
  logic             r_dz, w_short_dz, w_go_iter, w_last, w_accept;
  logic [W:0]       w_add, w_sub, w_mul_sum;
`ifdef ALU_SEQ_DIV_EN
  logic             r_is_div;
  logic [W:0]       w_div_shift, w_div_trial;
`endif

  assign result   = r_result;
  assign dz       = r_dz;
  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_cnt == CW'(1));
  assign w_add    = {1'b0, a} + {1'b0, b};
  assign w_sub    = {1'b0, a} - {1'b0, b};

  always_comb begin
    w_short_res = '0;
    w_short_dz  = 1'b0;
    w_go_iter   = 1'b0;
    case (sel)
      OP_ADD: w_short_res = {{(W-1){1'b0}}, w_add};
      OP_SUB: w_short_res = {{(W-1){1'b0}}, w_sub};
      OP_AND: w_short_res = {{W{1'b0}}, a & b};
      OP_XOR: w_short_res = {{W{1'b0}}, a ^ b};
      OP_MUL: w_go_iter   = 1'b1;
      OP_DIV: begin
`ifdef ALU_SEQ_DIV_EN
        if (b == '0) begin
          w_short_res = {a, {W{1'b1}}};
          w_short_dz  = 1'b1;
        end else begin
          w_go_iter = 1'b1;
        end
`else
        w_short_res = '0;
`endif
      end
      default: w_short_res = '0;
    endcase
  end

  // r_work: MUL keeps {partial product, remaining multiplier}; DIV keeps {remainder, dividend/quotient}
  always_comb begin
    w_mul_sum   = {1'b0, r_work[2*W-1:W]} + (r_work[0] ? {1'b0, r_opnd} : '0);
    w_work_step = {w_mul_sum, r_work[W-1:1]};
`ifdef ALU_SEQ_DIV_EN
    w_div_shift = {r_work[2*W-1:W], r_work[W-1]};
    w_div_trial = w_div_shift - {1'b0, r_opnd};
    if (r_is_div) begin
      if (w_div_trial[W])
        w_work_step = {w_div_shift[W-1:0], r_work[W-2:0], 1'b0};
      else
        w_work_step = {w_div_trial[W-1:0], r_work[W-2:0], 1'b1};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    valid  = 1'b0;
    busy   = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = w_go_iter ? S_ITER : S_SHORT;
      end
      S_SHORT: begin
        valid  = 1'b1;
        w_next = S_IDLE;
      end
      S_ITER: if (w_last) w_next = S_DONE;
      S_DONE: begin
        valid  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_dz     <= 1'b0;
      r_work   <= '0;
      r_opnd   <= '0;
      r_cnt    <= '0;
`ifdef ALU_SEQ_DIV_EN
      r_is_div <= 1'b0;
`endif
    end else if (w_accept) begin
      r_work <= {{W{1'b0}}, b};
      r_opnd <= a;
      r_cnt  <= CW'(W);
`ifdef ALU_SEQ_DIV_EN
      r_is_div <= (sel == OP_DIV);
      if (sel == OP_DIV) begin
        r_work <= {{W{1'b0}}, a};
        r_opnd <= b;
      end
`endif
      if (!w_go_iter) begin
        r_result <= w_short_res;
        r_dz     <= w_short_dz;
      end
    end else if (r_state == S_ITER) begin
      r_work <= w_work_step;
      r_cnt  <= r_cnt - CW'(1);
      if (w_last) begin
        r_result <= w_work_step;
        r_dz     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (W=8) with an expected-result scoreboard.
// DIV expectations follow ALU_SEQ_DIV_EN the same way the design does.
module tb_alu_seq;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_NP7 = 3'b111;

  logic        clk, reset, start;
  logic [2:0]  sel;
  logic [7:0]  a, b;
  logic [15:0] result;
  logic        valid, busy, dz;

  typedef struct packed {
    logic [15:0] res;
    logic        dz;
    logic [31:0] lat;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] last_res = '0;

  alu_seq #(.W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .sel(sel), .a(a), .b(b),
    .result(result), .valid(valid), .busy(busy), .dz(dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one op at a negedge, waits (bounded) for valid, checks against the popped expectation.
  // poke_at > 0 raises an unrelated ADD start in that cycle of the wait, which must be ignored.
  task automatic run_op(input logic [2:0] op, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [15:0] eres, input logic edz, input int elat, input int poke_at);
    exp_t e;
    int   lat;
    @(negedge clk);
    sel = op; a = ia; b = ib; start = 1'b1;
    e.res = eres; e.dz = edz; e.lat = elat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; sel = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
    lat = 1;
    while (!valid && lat < 40) begin
      chk("busy_wait", {31'd0, busy}, 32'd1);
      chk("hold_wait", {16'd0, result}, {16'd0, last_res});
      if (lat == poke_at) begin
        start = 1'b1; sel = OP_ADD; a = 8'd1; b = 8'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    e = sb.pop_front();
    chk("valid", {31'd0, valid}, 32'd1);
    chk("latency", lat, e.lat);
    chk("result", {16'd0, result}, {16'd0, e.res});
    chk("dz", {31'd0, dz}, {31'd0, e.dz});
    chk("busy_valid", {31'd0, busy}, 32'd1);
    last_res = e.res;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // reset with start held high: reset must win
    reset = 1'b1; start = 1'b1; sel = OP_ADD; a = 8'd1; b = 8'd1;
    repeat (2) @(negedge clk);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_dz", {31'd0, dz}, 32'd0);
    start = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    run_op(OP_ADD, 8'd200, 8'd100, 16'h012C, 1'b0, 1, 0);
    run_op(OP_ADD, 8'd255, 8'd255, 16'h01FE, 1'b0, 1, 0);
    run_op(OP_SUB, 8'd5,   8'd7,   16'h01FE, 1'b0, 1, 0);
    run_op(OP_SUB, 8'd9,   8'd9,   16'h0000, 1'b0, 1, 0);
    run_op(OP_SUB, 8'd200, 8'd55,  16'h0091, 1'b0, 1, 0);
    run_op(OP_AND, 8'hF0,  8'h3C,  16'h0030, 1'b0, 1, 0);
    run_op(OP_XOR, 8'hF0,  8'h3C,  16'h00CC, 1'b0, 1, 0);
    run_op(OP_NOP, 8'd5,   8'd6,   16'h0000, 1'b0, 1, 0);
    run_op(OP_ADD, 8'd3,   8'd4,   16'h0007, 1'b0, 1, 0);
    run_op(OP_NP7, 8'd5,   8'd6,   16'h0000, 1'b0, 1, 0);

    run_op(OP_MUL, 8'd255, 8'd255, 16'hFE01, 1'b0, 9, 3);
    run_op(OP_MUL, 8'd13,  8'd11,  16'h008F, 1'b0, 9, 0);
    run_op(OP_MUL, 8'd0,   8'd77,  16'h0000, 1'b0, 9, 0);
    run_op(OP_MUL, 8'd1,   8'd255, 16'h00FF, 1'b0, 9, 0);
    run_op(OP_MUL, 8'd128, 8'd2,   16'h0100, 1'b0, 9, 0);

`ifdef ALU_SEQ_DIV_EN
    run_op(OP_DIV, 8'd200, 8'd7,   16'h041C, 1'b0, 9, 0);
    run_op(OP_DIV, 8'd255, 8'd255, 16'h0001, 1'b0, 9, 0);
    run_op(OP_DIV, 8'd7,   8'd200, 16'h0700, 1'b0, 9, 0);
    run_op(OP_DIV, 8'd255, 8'd1,   16'h00FF, 1'b0, 9, 0);
    run_op(OP_DIV, 8'd13,  8'd0,   16'h0DFF, 1'b1, 1, 0);
    run_op(OP_ADD, 8'd1,   8'd2,   16'h0003, 1'b0, 1, 0);
    run_op(OP_DIV, 8'd13,  8'd0,   16'h0DFF, 1'b1, 1, 0);
`else
    run_op(OP_DIV, 8'd200, 8'd7,   16'h0000, 1'b0, 1, 0);
    run_op(OP_ADD, 8'd1,   8'd2,   16'h0003, 1'b0, 1, 0);
    run_op(OP_DIV, 8'd13,  8'd0,   16'h0000, 1'b0, 1, 0);
`endif

    // MUL aborted by reset at t+4; no valid pulse, outputs cleared at t+5
    @(negedge clk);
    sel = OP_MUL; a = 8'd255; b = 8'd255; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk("abort_busy", {31'd0, busy}, 32'd1);
      chk("abort_novalid", {31'd0, valid}, 32'd0);
      if (i < 3) @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy0", {31'd0, busy}, 32'd0);
    chk("abort_result0", {16'd0, result}, 32'd0);
    chk("abort_valid0", {31'd0, valid}, 32'd0);
    chk("abort_dz0", {31'd0, dz}, 32'd0);
    last_res = 16'h0000;
    run_op(OP_ADD, 8'd1, 8'd1, 16'h0002, 1'b0, 1, 0);

    @(negedge clk);
    chk("post_valid_low", {31'd0, valid}, 32'd0);
    chk("post_busy_low", {31'd0, busy}, 32'd0);
    chk("post_hold", {16'd0, result}, {16'd0, last_res});
    chk("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
